// File: rtl/mem_access_unit.sv
// mem_access_unit: single-issue load/store execute stage.
// Computes the effective address of an issued memory uop, runs one
// request/acknowledge transaction on the data memory port, aligns and
// extends load data, and returns one writeback per accepted uop.
// Misaligned uops skip the memory port and write back with a flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no transaction; may accept a uop when not busy
// S_REQ   | request on the memory port, waiting for ack; ack -> writeback
// S_DRAIN | flushed while waiting; keep request up until ack, drop result

package mem_access_pkg;

    localparam int XLEN_P = 32;

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_type_t;

    typedef struct packed {
        logic              valid;
        logic [5:0]        tag;
        mem_type_t         mem_type;
        logic [1:0]        mem_size;
        logic              mem_unsigned;
        logic [XLEN_P-1:0] imm;
    } micro_op_t;

endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN   = XLEN_P,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_en,
    input  micro_op_t         uop_in,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              ex_busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output micro_op_t         wb_uop,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state;
    micro_op_t   uop_q;
    logic [1:0]  off_q;

    logic [XLEN-1:0]   eff_addr;
    logic [1:0]        off;
    logic              misalign;
    logic              accept;
    logic [XLEN-1:0]   wdata_lane;
    logic [STRB_W-1:0] strb_lane;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   load_ext;

    // Busy while a transaction is open, or while a misalign writeback is
    // being presented (that cycle is reserved for the writeback).
    assign ex_busy = (state != S_IDLE) | (wb_valid & wb_misalign);

    // Effective address, alignment check and lane placement of store data.
    always_comb begin
        eff_addr = rs1_data + XLEN'(uop_in.imm);
        off      = eff_addr[1:0];
        misalign = 1'b0;
        strb_lane = '0;
        case (uop_in.mem_size)
            2'd0: begin
                misalign  = 1'b0;
                strb_lane = STRB_W'(1) << off;
            end
            2'd1: begin
                misalign  = eff_addr[0];
                strb_lane = STRB_W'(3) << off;
            end
            default: begin
                misalign  = |eff_addr[1:0];
                strb_lane = STRB_W'(4'hF);
            end
        endcase
        wdata_lane = rs2_data << {off, 3'b000};
        accept     = uop_in.valid & ~clear_en & ~ex_busy;
    end

    // Load data alignment and sign/zero extension for the uop in flight.
    always_comb begin
        rd_shift = dmem_rdata >> {off_q, 3'b000};
        load_ext = dmem_rdata;
        case (uop_q.mem_size)
            2'd0: begin
                if (uop_q.mem_unsigned)
                    load_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
                else
                    load_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            end
            2'd1: begin
                if (uop_q.mem_unsigned)
                    load_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
                else
                    load_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            end
            default: load_ext = dmem_rdata;
        endcase
    end

    // Control FSM with registered memory-port and writeback outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            uop_q       <= '0;
            off_q       <= 2'd0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_wstrb  <= '0;
            wb_valid    <= 1'b0;
            wb_uop      <= '0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            // No memory access; report the fault next cycle.
                            wb_valid    <= 1'b1;
                            wb_misalign <= 1'b1;
                            wb_uop      <= uop_in;
                            wb_data     <= '0;
                        end else begin
                            uop_q      <= uop_in;
                            off_q      <= off;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (uop_in.mem_type == MEM_ST);
                            dmem_addr  <= {eff_addr[XLEN-1:2], 2'b00};
                            dmem_wdata <= wdata_lane;
                            dmem_wstrb <= strb_lane;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= S_IDLE;
                        if (!clear_en) begin
                            wb_valid <= 1'b1;
                            wb_uop   <= uop_q;
                            wb_data  <= (uop_q.mem_type == MEM_LD) ? load_ext : '0;
                        end
                    end else if (clear_en) begin
                        // The request cannot be withdrawn; finish it silently.
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected memory
// requests and writebacks; a memory responder and a writeback monitor
// pop and compare independently.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_en = 1'b0;
    micro_op_t   uop_in = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        ex_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    micro_op_t   wb_uop;
    logic [31:0] wb_data;
    logic        wb_misalign;

    mem_access_unit #(.XLEN(32), .STRB_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .clear_en(clear_en),
        .uop_in(uop_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_busy(ex_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_uop(wb_uop), .wb_data(wb_data),
        .wb_misalign(wb_misalign)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        micro_op_t   uop;
        logic [31:0] data;
        logic        mis;
        int          cyc;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_exp_t;

    typedef struct {
        int          wait_n;
        logic [31:0] rdata;
    } mem_rsp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    mem_rsp_t mem_q[$];

    int tests = 0;
    int fails = 0;
    logic [5:0] tag_ctr = 6'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: byte-level view of the access.
    function automatic void ref_model(
        input  logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
        input  logic [31:0] rdata, input logic [1:0] size, input logic uns,
        output logic mis, output logic [31:0] waddr, output logic [31:0] wdata,
        output logic [3:0] strb, output logic [31:0] ldval);
        logic [31:0] ea;
        longint unsigned t;
        longint unsigned v;
        int nb;
        int o;
        ea = rs1 + imm;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        o = int'(ea % 4);
        mis = ((ea % nb) != 0);
        waddr = ea - 32'(o);
        t = longint'(rs2) << (8 * o);
        wdata = t[31:0];
        strb = 4'b0;
        for (int i = 0; i < nb; i++)
            if (o + i < 4) strb[o+i] = 1'b1;
        v = 0;
        for (int i = 0; i < nb; i++)
            if (o + i < 4) v = v | (((longint'(rdata) >> (8 * (o + i))) & 64'hFF) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
        ldval = v[31:0];
    endfunction

    task automatic issue(input logic is_st, input logic [1:0] size, input logic uns,
                         input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] rs2, input logic [31:0] rdata,
                         input int w, input bit expect_wb);
        logic mis;
        logic [31:0] waddr, wdata, ldval;
        logic [3:0] strb;
        micro_op_t u;
        int n;
        int t0;
        wb_exp_t e;
        req_exp_t r;
        mem_rsp_t m;
        n = 0;
        @(negedge clock);
        while (ex_busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (ex_busy) flag("issue_timeout");
        ref_model(rs1, imm, rs2, rdata, size, uns, mis, waddr, wdata, strb, ldval);
        u = '0;
        u.valid = 1'b1;
        u.tag = tag_ctr;
        tag_ctr++;
        u.mem_type = is_st ? MEM_ST : MEM_LD;
        u.mem_size = size;
        u.mem_unsigned = uns;
        u.imm = imm;
        uop_in = u;
        rs1_data = rs1;
        rs2_data = rs2;
        t0 = cyc;
        if (!mis) begin
            r.we = is_st; r.addr = waddr; r.wdata = wdata; r.strb = strb;
            req_q.push_back(r);
            m.wait_n = w; m.rdata = rdata;
            mem_q.push_back(m);
        end
        if (expect_wb) begin
            e.uop = u;
            e.data = (mis || is_st) ? 32'd0 : ldval;
            e.mis = mis;
            e.cyc = mis ? t0 + 1 : t0 + 2 + w;
            wb_q.push_back(e);
        end
        @(negedge clock);
        uop_in = '0;
        check("busy_after_accept", 64'(ex_busy), 64'd1);
        if (mis) check("no_req_on_misalign", 64'(dmem_req), 64'd0);
    endtask

    // Memory responder: checks each request and acks after its wait count.
    initial begin : responder
        bit in_txn = 0;
        int cnt = 0;
        req_exp_t cur;
        mem_rsp_t rsp;
        forever begin
            @(negedge clock);
            dmem_ack = 1'b0;
            if (!reset_n) begin
                in_txn = 0;
                continue;
            end
            if (in_txn && !dmem_req) in_txn = 0;
            if (dmem_req && !in_txn) begin
                if (req_q.size() == 0 || mem_q.size() == 0) begin
                    flag("unexpected_dmem_req");
                    cur.we = dmem_we; cur.addr = dmem_addr; cur.wdata = dmem_wdata; cur.strb = dmem_wstrb;
                    rsp.wait_n = 0; rsp.rdata = 32'd0;
                end else begin
                    cur = req_q.pop_front();
                    rsp = mem_q.pop_front();
                    check("req_we", 64'(dmem_we), 64'(cur.we));
                    check("req_addr", 64'(dmem_addr), 64'(cur.addr));
                    if (cur.we) begin
                        check("req_wdata", 64'(dmem_wdata), 64'(cur.wdata));
                        check("req_wstrb", 64'(dmem_wstrb), 64'(cur.strb));
                    end
                end
                cnt = rsp.wait_n;
                in_txn = 1;
            end
            if (in_txn) begin
                if (cnt == 0) begin
                    check("req_addr_stable", 64'(dmem_addr), 64'(cur.addr));
                    if (cur.we) check("req_wdata_stable", 64'(dmem_wdata), 64'(cur.wdata));
                    dmem_ack = 1'b1;
                    dmem_rdata = rsp.rdata;
                    in_txn = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Writeback monitor.
    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && wb_valid) begin
                if (wb_q.size() == 0) begin
                    flag("unexpected_wb_valid");
                end else begin
                    e = wb_q.pop_front();
                    check("wb_uop", 64'(wb_uop), 64'(e.uop));
                    check("wb_data", 64'(wb_data), 64'(e.data));
                    check("wb_misalign", 64'(wb_misalign), 64'(e.mis));
                    check("wb_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_busy"}, 64'(ex_busy), 64'd0);
        check({tag, "_dmem_req"}, 64'(dmem_req), 64'd0);
        check({tag, "_dmem_we"}, 64'(dmem_we), 64'd0);
        check({tag, "_dmem_addr"}, 64'(dmem_addr), 64'd0);
        check({tag, "_dmem_wdata"}, 64'(dmem_wdata), 64'd0);
        check({tag, "_dmem_wstrb"}, 64'(dmem_wstrb), 64'd0);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_wb_uop"}, 64'(wb_uop), 64'd0);
        check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
        check({tag, "_wb_misalign"}, 64'(wb_misalign), 64'd0);
    endtask

    initial begin : stimulus
        int n;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed cases.
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'd4, 32'd0, 32'hDEADBEEF, 0, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'h1000, 32'd3, 32'd0, 32'h80000000, 0, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h1000, 32'd3, 32'd0, 32'h80000000, 1, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h2000, 32'd2, 32'h1234ABCD, 32'h55555555, 3, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'd2, 32'd0, 32'h0, 0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h3000, 32'd2, 32'd0, 32'h8001_7F00, 2, 1'b1);

        // Flush while waiting: ack two cycles later, result dropped.
        issue(1'b0, 2'd2, 1'b0, 32'h4000, 32'd8, 32'd0, 32'hCAFEF00D, 3, 1'b0);
        @(negedge clock);
        clear_en = 1'b1;
        @(negedge clock);
        clear_en = 1'b0;
        @(negedge clock);
        check("drain_req_held", 64'(dmem_req), 64'd1);
        @(negedge clock);
        check("drain_busy_low", 64'(ex_busy), 64'd0);

        // Flush in the same cycle as ack.
        issue(1'b1, 2'd0, 1'b0, 32'h5000, 32'd1, 32'hA5, 32'h0, 0, 1'b0);
        clear_en = 1'b1;
        @(negedge clock);
        clear_en = 1'b0;
        check("clear_ack_busy_low", 64'(ex_busy), 64'd0);

        // Flush in IDLE drops the presented uop.
        uop_in = '0;
        uop_in.valid = 1'b1;
        uop_in.mem_size = 2'd2;
        rs1_data = 32'h6000;
        clear_en = 1'b1;
        @(negedge clock);
        uop_in = '0;
        clear_en = 1'b0;
        check("clear_idle_no_req", 64'(dmem_req), 64'd0);
        check("clear_idle_busy", 64'(ex_busy), 64'd0);

        // Asynchronous reset in the middle of a request.
        issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'd0, 32'd0, 32'h12345678, 5, 1'b0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        #1 reset_n = 1'b1;
        @(negedge clock);
        issue(1'b0, 2'd1, 1'b1, 32'h7000, 32'd6, 32'd0, 32'hBEEF0000, 1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  $urandom, 32'($urandom_range(0, 15)), $urandom, $urandom,
                  int'($urandom_range(0, 3)), 1'b1);
        end

        n = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (wb_q.size() != 0) flag("wb_drain_timeout");
        if (req_q.size() != 0) flag("req_drain_timeout");
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
